// File: rtl/layer_compositor_if.sv
// -----------------------------------------------------------------------------
// layer_compositor_if
// Pixel-path bundle for the VGA layer compositor. The clock and reset stay
// plain ports on the compositor; everything else travels through this bundle.
//
//   Pixel stream   : x_pos, y_pos, frame_start       (stream source -> compositor)
//   Window config  : win_x0/x1/y0/y1, layer_en, layer_key_en
//   Fetched data   : layer_data, bg_data             (PIPE_LAT after coordinates)
//   Dim control    : dim_req, keep_x0/x1/y0/y1
//   Results        : vga_out, hit_layer, dim_level   (compositor -> DAC side)
//
// Modports: master = the side feeding coordinates/data and consuming results,
//           slave  = the compositor itself.
// -----------------------------------------------------------------------------
interface layer_compositor_if #(
  parameter int N_LAYERS = 4,
  parameter int COORD_W  = 10
);
  localparam int HIT_W = $clog2(N_LAYERS + 1);

  logic [COORD_W-1:0]          x_pos;
  logic [COORD_W-1:0]          y_pos;
  logic                        frame_start;
  logic [N_LAYERS*COORD_W-1:0] win_x0;
  logic [N_LAYERS*COORD_W-1:0] win_x1;
  logic [N_LAYERS*COORD_W-1:0] win_y0;
  logic [N_LAYERS*COORD_W-1:0] win_y1;
  logic [N_LAYERS-1:0]         layer_en;
  logic [N_LAYERS-1:0]         layer_key_en;
  logic [N_LAYERS*24-1:0]      layer_data;
  logic [23:0]                 bg_data;
  logic                        dim_req;
  logic [COORD_W-1:0]          keep_x0;
  logic [COORD_W-1:0]          keep_x1;
  logic [COORD_W-1:0]          keep_y0;
  logic [COORD_W-1:0]          keep_y1;
  logic [23:0]                 vga_out;
  logic [HIT_W-1:0]            hit_layer;
  logic [7:0]                  dim_level;

  modport master (
    output x_pos, y_pos, frame_start,
    output win_x0, win_x1, win_y0, win_y1, layer_en, layer_key_en,
    output layer_data, bg_data,
    output dim_req, keep_x0, keep_x1, keep_y0, keep_y1,
    input  vga_out, hit_layer, dim_level
  );

  modport slave (
    input  x_pos, y_pos, frame_start,
    input  win_x0, win_x1, win_y0, win_y1, layer_en, layer_key_en,
    input  layer_data, bg_data,
    input  dim_req, keep_x0, keep_x1, keep_y0, keep_y1,
    output vga_out, hit_layer, dim_level
  );
endinterface

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
// Merges a background pixel stream with N_LAYERS rectangular overlay windows
// (index 0 = highest priority, optional per-layer luma key) and dims every
// pixel outside a keep-out rectangle by a frame-synchronous dim level.
//
// Ports:
//   vga_clk  in  pixel clock
//   reset    in  synchronous, active-high
//   bus      layer_compositor_if.slave (coordinates, window config, fetched
//            data, dim control in; vga_out / hit_layer / dim_level out)
//
// Pipeline (coordinates at cycle 0):
//   stage A : window / keep-out compares, registered, then delayed so the
//             per-pixel tag lines up with data arriving at cycle PIPE_LAT
//   stage B : priority + key selection  } combinational, one register into
//   stage C : keep-out dimming          } vga_out/hit_layer -> PIPE_LAT+1
//
// Build option: define LAYER_COMPOSITOR_FADE_EN for the four-state fade FSM;
// without it dim_level jumps to DIM_MAX / 0 at each frame_start.
// -----------------------------------------------------------------------------
module layer_compositor #(
  parameter int         N_LAYERS   = 4,
  parameter int         COORD_W    = 10,
  parameter int         PIPE_LAT   = 2,
  parameter logic [7:0] KEY_THRESH = 8'h40,
  parameter int         DIM_MAX    = 40,
  parameter int         DIM_STEP   = 4
) (
  input  logic               vga_clk,
  input  logic               reset,
  layer_compositor_if.slave  bus
);
  localparam int HIT_W = $clog2(N_LAYERS + 1);

  // Per-pixel decisions made at stage A and carried alongside the fetch.
  // The key enable travels with the hit so all per-pixel config is sampled
  // together with the coordinates.
  typedef struct packed {
    logic [N_LAYERS-1:0] hit;
    logic [N_LAYERS-1:0] key_en;
    logic                keep;
  } tag_t;

  // ---------------------------------------------------------------------------
  // Stage A: window and keep-out compares
  // ---------------------------------------------------------------------------
  tag_t tag_a;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tag_a        = '0;
    tag_a.key_en = bus.layer_key_en;
    // An inverted window (x0>x1 or y0>y1) fails one of the two bounds for
    // every coordinate, so it never hits without any special casing.
    for (int i = 0; i < N_LAYERS; i++) begin
      tag_a.hit[i] = bus.layer_en[i]
                  && (bus.x_pos >= bus.win_x0[i*COORD_W +: COORD_W])
                  && (bus.x_pos <= bus.win_x1[i*COORD_W +: COORD_W])
                  && (bus.y_pos >= bus.win_y0[i*COORD_W +: COORD_W])
                  && (bus.y_pos <= bus.win_y1[i*COORD_W +: COORD_W]);
    end
    tag_a.keep = (bus.x_pos >= bus.keep_x0) && (bus.x_pos <= bus.keep_x1)
              && (bus.y_pos >= bus.keep_y0) && (bus.y_pos <= bus.keep_y1);
  end

  // Element 0 is the stage A register; element PIPE_LAT-1 is aligned with
  // the fetched data.
  tag_t tag_q [PIPE_LAT];

  // NOTE: the delay line is a handful of flops, not a memory, so it is cleared
  // on reset; stale hits must not leak into the first pixels after release.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int s = 0; s < PIPE_LAT; s++) tag_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns this into a shift register.
      tag_q[0] <= tag_a;
      for (int s = 1; s < PIPE_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  tag_t tag_b;
  assign tag_b = tag_q[PIPE_LAT-1];

  // ---------------------------------------------------------------------------
  // Stage B: priority selection with luma keying
  // ---------------------------------------------------------------------------
  function automatic logic is_dark(input logic [23:0] px);
    return (px[23:16] <= KEY_THRESH) && (px[15:8] <= KEY_THRESH)
        && (px[7:0] <= KEY_THRESH);
  endfunction

  logic [23:0]      pix_sel;
  logic [HIT_W-1:0] idx_sel;

  always_comb begin
    pix_sel = bus.bg_data;
    idx_sel = HIT_W'(N_LAYERS);
    // Walk from lowest to highest priority so the lowest opaque index wins.
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (tag_b.hit[i]
          && !(tag_b.key_en[i] && is_dark(bus.layer_data[i*24 +: 24]))) begin
        pix_sel = bus.layer_data[i*24 +: 24];
        idx_sel = HIT_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage C: keep-out dimming and output register
  // ---------------------------------------------------------------------------
  logic [7:0] dim_q, dim_d;

  function automatic logic [7:0] sat_sub(input logic [7:0] ch, input logic [7:0] d);
    return (ch > d) ? ch - d : 8'd0;
  endfunction

  logic [23:0]      vga_d, vga_q;
  logic [HIT_W-1:0] hit_d, hit_q;

  always_comb begin
    hit_d = idx_sel;
    vga_d = pix_sel;
    if (!tag_b.keep) begin
      vga_d = {sat_sub(pix_sel[23:16], dim_q),
               sat_sub(pix_sel[15:8],  dim_q),
               sat_sub(pix_sel[7:0],   dim_q)};
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vga_q <= '0;
      hit_q <= HIT_W'(N_LAYERS);
    end else begin
      vga_q <= vga_d;
      hit_q <= hit_d;
    end
  end

  assign bus.vga_out   = vga_q;
  assign bus.hit_layer = hit_q;
  assign bus.dim_level = dim_q;

  // ---------------------------------------------------------------------------
  // Dim level control: only ever changes in a frame_start cycle
  // ---------------------------------------------------------------------------
`ifdef LAYER_COMPOSITOR_FADE_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_e;

  localparam logic [8:0] MAX9  = 9'(DIM_MAX);
  localparam logic [8:0] STEP9 = 9'(DIM_STEP);

  fade_state_e state_q, state_d;

  // Nine-bit sum so level+STEP cannot wrap before the clamp.
  logic [8:0] sum_up;
  logic [7:0] lvl_up, lvl_dn;

  always_comb begin
    sum_up = {1'b0, dim_q} + STEP9;
    lvl_up = (sum_up > MAX9) ? MAX9[7:0] : sum_up[7:0];
    lvl_dn = (dim_q > STEP9[7:0]) ? dim_q - STEP9[7:0] : 8'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      dim_q   <= '0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
    end
  end

  // A step down that lands on zero goes straight to IDLE from any state.
  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    if (bus.frame_start) begin
      unique case (state_q)
        IDLE: begin
          if (bus.dim_req) begin
            state_d = FADE_IN;
            dim_d   = lvl_up;
          end
        end
        FADE_IN: begin
          if (bus.dim_req) begin
            dim_d = lvl_up;
            if (lvl_up == MAX9[7:0]) state_d = HOLD;
          end else begin
            dim_d   = lvl_dn;
            state_d = (lvl_dn == 8'd0) ? IDLE : FADE_OUT;
          end
        end
        HOLD: begin
          if (!bus.dim_req) begin
            dim_d   = lvl_dn;
            state_d = (lvl_dn == 8'd0) ? IDLE : FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (bus.dim_req) begin
            dim_d   = lvl_up;
            state_d = FADE_IN;
          end else begin
            dim_d   = lvl_dn;
            state_d = (lvl_dn == 8'd0) ? IDLE : FADE_OUT;
          end
        end
        default: begin
          state_d = IDLE;
          dim_d   = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    dim_d = dim_q;
    if (bus.frame_start) dim_d = bus.dim_req ? 8'(DIM_MAX) : 8'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) dim_q <= '0;
    else       dim_q <= dim_d;
  end
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
// Directed bench for layer_compositor. Stimulus drives one pixel per cycle and
// pushes the hand-computed expected output into a scoreboard queue tagged with
// the cycle it is due; a monitor on the falling edge pops and compares.
// Fetched data is delayed PIPE_LAT cycles by a small fetch-latency model.
// Expected dim levels follow LAYER_COMPOSITOR_FADE_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_layer_compositor;
  localparam int N  = 4;
  localparam int CW = 10;
  localparam int PL = 2;
  localparam int HW = $clog2(N + 1);
  localparam int NSEQ = 41;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_compositor_if #(.N_LAYERS(N), .COORD_W(CW)) bus ();

  layer_compositor #(
    .N_LAYERS(N), .COORD_W(CW), .PIPE_LAT(PL),
    .KEY_THRESH(8'h40), .DIM_MAX(40), .DIM_STEP(4)
  ) dut (
    .vga_clk(clk),
    .reset  (rst),
    .bus    (bus)
  );

  typedef struct {
    int               due;
    logic [23:0]      vga;
    logic [HW-1:0]    hit;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle settings, applied to the DUT together with the coordinates.
  logic         cfg_rst = 1'b1;
  logic         cfg_fs  = 1'b0;
  logic         cfg_req = 1'b0;
  logic [N-1:0] cfg_en  = '0;
  logic [N-1:0] cfg_key = '0;

  logic [N*24-1:0] ld_fifo [PL];
  logic [23:0]     bg_fifo [PL];

  bit req_seq [NSEQ] = '{1,1,1,1,1,1,1,1,1,1,1,1,
                         0,0,0,0,0,0,0,0,0,0,0,
                         1,1,1,1,1,1,1,1,1,1,
                         0,0, 1, 1, 0,0,0,0};
`ifdef LAYER_COMPOSITOR_FADE_EN
  int exp_lvl [NSEQ] = '{4,8,12,16,20,24,28,32,36,40,40,40,
                         36,32,28,24,20,16,12,8,4,0,0,
                         4,8,12,16,20,24,28,32,36,40,
                         36,32, 36, 40, 36,32,28,24};
  int exp_after_rst = 4;
`else
  int exp_lvl [NSEQ] = '{40,40,40,40,40,40,40,40,40,40,40,40,
                         0,0,0,0,0,0,0,0,0,0,0,
                         40,40,40,40,40,40,40,40,40,40,
                         0,0, 40, 40, 0,0,0,0};
  int exp_after_rst = 40;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*24-1:0] mk(input logic [23:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  // One pixel per call; never skip a clock while checked pixels are in flight.
  task automatic pix(input logic [CW-1:0] x, input logic [CW-1:0] y,
                     input logic [N*24-1:0] ld, input logic [23:0] bg,
                     input bit chk, input logic [23:0] ev, input logic [HW-1:0] eh);
    @(posedge clk);
    #1;
    rst              = cfg_rst;
    bus.frame_start  = cfg_fs;
    bus.dim_req      = cfg_req;
    bus.layer_en     = cfg_en;
    bus.layer_key_en = cfg_key;
    bus.layer_data   = ld_fifo[PL-1];
    bus.bg_data      = bg_fifo[PL-1];
    for (int i = PL - 1; i > 0; i--) begin
      ld_fifo[i] = ld_fifo[i-1];
      bg_fifo[i] = bg_fifo[i-1];
    end
    ld_fifo[0] = ld;
    bg_fifo[0] = bg;
    bus.x_pos  = x;
    bus.y_pos  = y;
    if (chk) sb.push_back('{due: cyc + PL + 1, vga: ev, hit: eh});
  endtask

  task automatic idle();
    pix('0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    repeat (PL + 2) idle();
  endtask

  task automatic do_frame(input bit req, input int exp, input int idx);
    cfg_req = req;
    cfg_fs  = 1'b1;
    idle();
    cfg_fs  = 1'b0;
    idle();
    @(negedge clk);
    check($sformatf("dim_level[%0d]", idx), 32'(bus.dim_level), 32'(exp));
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, " vga_out"},   {8'h0, bus.vga_out}, 32'h0);
    check({tag, " hit_layer"}, 32'(bus.hit_layer),  32'(N));
    check({tag, " dim_level"}, 32'(bus.dim_level),  32'h0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: entry due cycle %0d never compared (now %0d)", mon_e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check("vga_out",   {8'h0, bus.vga_out}, {8'h0, mon_e.vga});
      check("hit_layer", 32'(bus.hit_layer),  32'(mon_e.hit));
    end
  end

  logic [N*24-1:0] ld_std;

  initial begin
    for (int i = 0; i < PL; i++) begin
      ld_fifo[i] = '0;
      bg_fifo[i] = '0;
    end
    bus.x_pos = '0; bus.y_pos = '0; bus.frame_start = 1'b0;
    bus.layer_en = '0; bus.layer_key_en = '0;
    bus.layer_data = '0; bus.bg_data = '0; bus.dim_req = 1'b0;
    // Layer 0: 90..110, layer 1: 80..120, layer 2: 200..210,
    // layer 3: x 300..299 (inverted), y full range.
    bus.win_x0 = {10'd300, 10'd200, 10'd80,  10'd90};
    bus.win_x1 = {10'd299, 10'd210, 10'd120, 10'd110};
    bus.win_y0 = {10'd0,   10'd200, 10'd80,  10'd90};
    bus.win_y1 = {10'd1023,10'd210, 10'd120, 10'd110};
    bus.keep_x0 = 10'd0; bus.keep_x1 = 10'd50;
    bus.keep_y0 = 10'd0; bus.keep_y1 = 10'd50;

    // Reset state
    cfg_rst = 1'b1;
    repeat (3) idle();
    check_reset_outputs("reset");
    cfg_rst = 1'b0;

    // Priority
    ld_std = mk(24'hABCDEF, 24'h0000FF, 24'h00FF00, 24'hFF0000);
    cfg_en = 4'b1111;
    pix(100, 100, ld_std, 24'h123456, 1, 24'hFF0000, 0);
    cfg_en = 4'b1110;
    pix(100, 100, ld_std, 24'h123456, 1, 24'h00FF00, 1);
    cfg_en = 4'b1100;
    pix(100, 100, ld_std, 24'h123456, 1, 24'h123456, HW'(N));

    // Luma key
    cfg_en = 4'b1111; cfg_key = 4'b0001;
    pix(100, 100, mk(24'hABCDEF, 24'h0000FF, 24'h00FF00, 24'h404040), 24'h123456, 1, 24'h00FF00, 1);
    cfg_en = 4'b0001;
    pix(100, 100, mk(24'hABCDEF, 24'h0000FF, 24'h00FF00, 24'h404040), 24'h123456, 1, 24'h123456, HW'(N));
    pix(100, 100, mk(24'hABCDEF, 24'h0000FF, 24'h00FF00, 24'h414040), 24'h123456, 1, 24'h414040, 0);
    pix(100, 100, mk(24'hABCDEF, 24'h0000FF, 24'h00FF00, 24'h404041), 24'h123456, 1, 24'h404041, 0);
    cfg_key = 4'b0000;
    pix(100, 100, mk(24'hABCDEF, 24'h0000FF, 24'h00FF00, 24'h404040), 24'h123456, 1, 24'h404040, 0);

    // Bounds of window 200..210
    cfg_en = 4'b0100;
    pix(200, 205, ld_std, 24'h123456, 1, 24'h0000FF, 2);
    pix(210, 205, ld_std, 24'h123456, 1, 24'h0000FF, 2);
    pix(199, 205, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    pix(211, 205, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    pix(205, 200, ld_std, 24'h123456, 1, 24'h0000FF, 2);
    pix(205, 210, ld_std, 24'h123456, 1, 24'h0000FF, 2);
    pix(205, 199, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    pix(205, 211, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    // Inverted window never hits
    cfg_en = 4'b1000;
    pix(299, 5, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    pix(300, 5, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    pix(1023, 1023, ld_std, 24'h123456, 1, 24'h123456, HW'(N));
    drain();

    // Fade up to full level
    for (int i = 0; i < 12; i++) do_frame(req_seq[i], exp_lvl[i], i);

    // Dimming at level 40, keep-out 0..50
    cfg_en = 4'b0000;
    pix(100, 100, ld_std, 24'h203050, 1, 24'h000828, HW'(N));
    pix(20,  20,  ld_std, 24'h203050, 1, 24'h203050, HW'(N));
    pix(50,  50,  ld_std, 24'h203050, 1, 24'h203050, HW'(N));
    pix(51,  50,  ld_std, 24'h203050, 1, 24'h000828, HW'(N));
    pix(50,  51,  ld_std, 24'h203050, 1, 24'h000828, HW'(N));
    cfg_en = 4'b0001;
    pix(100, 100, ld_std, 24'h203050, 1, 24'hD70000, 0);
    drain();

    // Fade out, re-request, partial fade-out
    for (int i = 12; i < NSEQ; i++) do_frame(req_seq[i], exp_lvl[i], i);

    // Reset mid-frame with a non-trivial picture on the output
    cfg_en = 4'b0000;
    repeat (PL + 2) pix(20, 20, ld_std, 24'hABCDEF, 1'b0, '0, '0);
    cfg_rst = 1'b1; cfg_fs = 1'b1; cfg_req = 1'b1;
    idle();
    cfg_fs = 1'b0;
    idle();
    check_reset_outputs("mid-reset");
    idle();
    idle();
    check_reset_outputs("reset-held");
    cfg_rst = 1'b0; cfg_req = 1'b0;
    cfg_en  = 4'b0001;
    pix(100, 100, ld_std, 24'h123456, 1, 24'hFF0000, 0);
    pix(20,  20,  ld_std, 24'hABCDEF, 1, 24'hABCDEF, HW'(N));
    drain();
    do_frame(1'b1, exp_after_rst, 99);

    // Wait (bounded) for the scoreboard to empty
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
